// File: rtl/cnu_min_sched_if.sv
// Stream bundle for the serial check-node min scheduler: message beats in,
// one min1/min2/index/sign result per row out.
interface cnu_min_sched_if #(
  parameter int BITS = 8,
  parameter int DEG  = 32,
  parameter int IDXW = (DEG > 1) ? $clog2(DEG) : 1
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [BITS-1:0] in_data;
  logic                   abort;
  logic                   out_valid;
  logic                   out_ready;
  logic [BITS-2:0]        min1;
  logic [BITS-2:0]        min2;
  logic [IDXW-1:0]        min1_idx;
  logic                   sign_prod;
  logic [DEG-1:0]         signs;

  modport master (
    output in_valid, in_data, abort, out_ready,
    input  in_ready, out_valid, min1, min2, min1_idx, sign_prod, signs
  );

  modport slave (
    input  in_valid, in_data, abort, out_ready,
    output in_ready, out_valid, min1, min2, min1_idx, sign_prod, signs
  );
endinterface

// File: rtl/cnu_min_sched.sv
// Serial min-sum check-node unit: one compare pair per cycle tracks min1,
// min2, min1 position and signs across DEG beats, then holds the row result.
//
// state | meaning
// ACC   | accepting beats of the current row, accumulators running
// OUT   | row complete, result held until out_ready
module cnu_min_sched #(
  parameter int BITS = 8,
  parameter int DEG  = 32
) (
  input  logic               clk,
  input  logic               rst,
  cnu_min_sched_if.slave     s
);
  localparam int IDXW = (DEG > 1) ? $clog2(DEG) : 1;

  typedef enum logic {ACC, OUT} state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] cnt, cnt_nxt;
  logic [BITS-2:0] min1_q, min1_nxt;
  logic [BITS-2:0] min2_q, min2_nxt;
  logic [IDXW-1:0] idx_q, idx_nxt;
  logic            sp_q, sp_nxt;
  logic [DEG-1:0]  signs_q, signs_nxt;
  logic            in_ready_c;
  logic            out_valid_c;

  logic            sgn;
  logic [BITS-1:0] abs_full;
  logic [BITS-2:0] mag;

  // Magnitude with saturation: only the most negative code overflows into the MSB.
  always_comb begin
    sgn      = s.in_data[BITS-1];
    abs_full = sgn ? (~s.in_data + BITS'(1)) : s.in_data;
    mag      = abs_full[BITS-1] ? '1 : abs_full[BITS-2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ACC;
      cnt     <= '0;
      min1_q  <= '1;
      min2_q  <= '1;
      idx_q   <= '0;
      sp_q    <= 1'b0;
      signs_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      min1_q  <= min1_nxt;
      min2_q  <= min2_nxt;
      idx_q   <= idx_nxt;
      sp_q    <= sp_nxt;
      signs_q <= signs_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    min1_nxt    = min1_q;
    min2_nxt    = min2_q;
    idx_nxt     = idx_q;
    sp_nxt      = sp_q;
    signs_nxt   = signs_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;

    case (state)
      ACC: begin
        in_ready_c = !s.abort;
        if (s.abort) begin
          cnt_nxt   = '0;
          min1_nxt  = '1;
          min2_nxt  = '1;
          idx_nxt   = '0;
          sp_nxt    = 1'b0;
          signs_nxt = '0;
        end else if (s.in_valid) begin
          // Strict less-than keeps the earlier index on ties.
          if (mag < min1_q) begin
            min2_nxt = min1_q;
            min1_nxt = mag;
            idx_nxt  = cnt;
          end else if (mag < min2_q) begin
            min2_nxt = mag;
          end
          sp_nxt         = sp_q ^ sgn;
          signs_nxt[cnt] = sgn;
          if (cnt == IDXW'(DEG - 1)) begin
            cnt_nxt   = '0;
            state_nxt = OUT;
          end else begin
            cnt_nxt = cnt + IDXW'(1);
          end
        end
      end
      OUT: begin
        out_valid_c = 1'b1;
        if (s.out_ready) begin
          min1_nxt  = '1;
          min2_nxt  = '1;
          idx_nxt   = '0;
          sp_nxt    = 1'b0;
          signs_nxt = '0;
          state_nxt = ACC;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  assign s.in_ready  = in_ready_c;
  assign s.out_valid = out_valid_c;
  assign s.min1      = min1_q;
  assign s.min2      = min2_q;
  assign s.min1_idx  = idx_q;
  assign s.sign_prod = sp_q;
  assign s.signs     = signs_q;
endmodule

// File: tb/tb_cnu_min_sched.sv
// Directed bench for cnu_min_sched at DEG=4, BITS=8 with hand-computed rows.
module tb_cnu_min_sched;
  localparam int BITS = 8;
  localparam int DEG  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  cnu_min_sched_if #(.BITS(BITS), .DEG(DEG)) bus ();

  cnu_min_sched #(.BITS(BITS), .DEG(DEG)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [BITS-1:0] v);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    tick();
  endtask

  task automatic check_res(input string tag, input logic [6:0] m1, input logic [6:0] m2,
                           input logic [1:0] idx, input logic sp, input logic [3:0] sg);
    check({tag, ".min1"}, 32'(bus.min1), 32'(m1));
    check({tag, ".min2"}, 32'(bus.min2), 32'(m2));
    check({tag, ".idx"}, 32'(bus.min1_idx), 32'(idx));
    check({tag, ".sp"}, 32'(bus.sign_prod), 32'(sp));
    check({tag, ".signs"}, 32'(bus.signs), 32'(sg));
  endtask

  logic signed [BITS-1:0] rows [3][4];
  logic [6:0] e_m1 [3];
  logic [6:0] e_m2 [3];
  logic [1:0] e_idx [3];
  logic       e_sp [3];
  logic [3:0] e_sg [3];

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check_res("rst", 7'd127, 7'd127, 2'd0, 1'b0, 4'b0000);
    rst = 1'b0;
    #1;
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // Row with a tie on magnitude 3
    send(8'sd5);
    send(-8'sd3);
    send(8'sd7);
    check("r1.pre_valid", 32'(bus.out_valid), 32'd0);
    send(-8'sd3);
    bus.in_valid = 1'b0;
    check("r1.out_valid", 32'(bus.out_valid), 32'd1);
    check("r1.in_ready", 32'(bus.in_ready), 32'd0);
    check_res("r1", 7'd3, 7'd3, 2'd1, 1'b0, 4'b1010);
    tick();
    check("r1.back_acc", 32'(bus.out_valid), 32'd0);
    check("r1.cleared", 32'(bus.min1), 32'd127);

    // Saturation of -128
    send(-8'sd128);
    send(8'sd127);
    send(-8'sd128);
    send(8'sd100);
    bus.in_valid = 1'b0;
    check("r2.out_valid", 32'(bus.out_valid), 32'd1);
    check_res("r2", 7'd100, 7'd127, 2'd3, 1'b0, 4'b0101);
    tick();

    // Backpressure: result held while out_ready low and in_valid keeps coming
    bus.out_ready = 1'b0;
    send(-8'sd10);
    send(8'sd20);
    send(-8'sd30);
    send(-8'sd40);
    bus.in_data = 8'sd1;
    for (int i = 0; i < 5; i++) begin
      check("bp.out_valid", 32'(bus.out_valid), 32'd1);
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
      check_res("bp", 7'd10, 7'd20, 2'd0, 1'b1, 4'b1101);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp.hs_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("bp.acc", 32'(bus.out_valid), 32'd0);
    send(8'sd4);
    send(8'sd3);
    send(8'sd2);
    check("bp.next_pre", 32'(bus.out_valid), 32'd0);
    send(8'sd1);
    bus.in_valid = 1'b0;
    check("bp.next_valid", 32'(bus.out_valid), 32'd1);
    check_res("bp.next", 7'd1, 7'd2, 2'd3, 1'b0, 4'b0000);
    tick();

    // Abort discards a partial row and the beat offered alongside it
    send(8'sd9);
    send(-8'sd9);
    bus.abort   = 1'b1;
    bus.in_data = 8'sd55;
    #1;
    check("ab.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.abort = 1'b0;
    check_res("ab.clr", 7'd127, 7'd127, 2'd0, 1'b0, 4'b0000);
    send(8'sd1);
    send(8'sd2);
    send(8'sd3);
    check("ab.pre_valid", 32'(bus.out_valid), 32'd0);
    send(8'sd4);
    bus.in_valid = 1'b0;
    check("ab.out_valid", 32'(bus.out_valid), 32'd1);
    check_res("ab", 7'd1, 7'd2, 2'd0, 1'b0, 4'b0000);
    tick();

    // Streaming: three rows, in_valid and out_ready held high throughout
    rows[0][0] = -8'sd1;  rows[0][1] = -8'sd1;  rows[0][2] = 8'sd0;    rows[0][3] = 8'sd5;
    rows[1][0] = 8'sd60;  rows[1][1] = -8'sd70; rows[1][2] = -8'sd128; rows[1][3] = -8'sd2;
    rows[2][0] = 8'sd3;   rows[2][1] = 8'sd3;   rows[2][2] = 8'sd3;    rows[2][3] = 8'sd3;
    e_m1[0] = 7'd0;  e_m2[0] = 7'd1;  e_idx[0] = 2'd2; e_sp[0] = 1'b0; e_sg[0] = 4'b0011;
    e_m1[1] = 7'd2;  e_m2[1] = 7'd60; e_idx[1] = 2'd3; e_sp[1] = 1'b1; e_sg[1] = 4'b1110;
    e_m1[2] = 7'd3;  e_m2[2] = 7'd3;  e_idx[2] = 2'd0; e_sp[2] = 1'b0; e_sg[2] = 4'b0000;
    bus.in_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        check("st.no_early", 32'(bus.out_valid), 32'd0);
        bus.in_data = rows[r][i];
        tick();
      end
      check("st.out_valid", 32'(bus.out_valid), 32'd1);
      check_res("st", e_m1[r], e_m2[r], e_idx[r], e_sp[r], e_sg[r]);
      tick();
    end
    bus.in_valid = 1'b0;
    check("st.end", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-row
    send(8'sd1);
    send(-8'sd2);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_res("arst.row", 7'd127, 7'd127, 2'd0, 1'b0, 4'b0000);
    #2;
    rst = 1'b0;
    tick();

    // Asynchronous reset while holding a result
    send(8'sd8);
    send(8'sd7);
    send(8'sd6);
    send(8'sd5);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("arst.pre_out", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("arst.out_valid", 32'(bus.out_valid), 32'd0);
    check_res("arst.out", 7'd127, 7'd127, 2'd0, 1'b0, 4'b0000);
    #2;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    send(-8'sd5);
    send(8'sd6);
    send(-8'sd7);
    send(8'sd8);
    bus.in_valid = 1'b0;
    check("post.out_valid", 32'(bus.out_valid), 32'd1);
    check_res("post", 7'd5, 7'd6, 2'd0, 1'b0, 4'b0101);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
